// File: rtl/mips_pkg.sv
// Shared MIPS definitions: mult/div op encodings, unit state and control flags.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'b00,
    MD_RUN    = 2'b01,
    MD_FINISH = 2'b10
  } md_state_t;

  // Per-operation flags captured at start and consumed at FINISH.
  typedef struct packed {
    logic is_div;
    logic res_neg;
    logic rem_neg;
    logic div0;
  } md_ctl_t;

endpackage

// File: rtl/md_abs_fixup.sv
// Conditional two's-complement negate: absolute value at start, sign fixup at finish.
module md_abs_fixup #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_c_o
);

  assign res_c_o = neg_i ? (W'(0) - val_i) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift-add or
// restoring shift-subtract step per cycle, result after WIDTH+1 edges.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  md_state_t        state_q, state_d;
  md_ctl_t          ctl_q, ctl_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             signed_op;
  logic [DW-1:0]    fix_a_val, fix_a_res;
  logic             fix_a_neg;
  logic [WIDTH-1:0] fix_b_val, fix_b_res;
  logic             fix_b_neg;
  logic [WIDTH:0]   mul_sum, div_diff;

  assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);

  // Multiply step adds the multiplicand into the upper half; divide step trial-subtracts.
  assign mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_diff = acc_q[DW-1:WIDTH-1] - {1'b0, opnd_q};

  // Wide instance: |a| at start, product or quotient negation at finish.
  md_abs_fixup #(.W(DW)) u_fix_a (
    .val_i   (fix_a_val),
    .neg_i   (fix_a_neg),
    .res_c_o (fix_a_res)
  );

  // Narrow instance: |b| at start, remainder negation at finish.
  md_abs_fixup #(.W(WIDTH)) u_fix_b (
    .val_i   (fix_b_val),
    .neg_i   (fix_b_neg),
    .res_c_o (fix_b_res)
  );

  always_comb begin
    state_d   = state_q;
    ctl_d     = ctl_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fix_a_val = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    fix_a_neg = signed_op & a_i[WIDTH-1];
    fix_b_val = b_i;
    fix_b_neg = signed_op & b_i[WIDTH-1];

    unique case (state_q)
      MD_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i) begin
          ctl_d.is_div  = op_i[1];
          ctl_d.res_neg = signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          ctl_d.rem_neg = signed_op & a_i[WIDTH-1];
          ctl_d.div0    = op_i[1] & (b_i == '0);
          acc_d   = {{WIDTH{1'b0}}, (op_i[1] ? fix_a_res[WIDTH-1:0] : fix_b_res)};
          opnd_d  = op_i[1] ? fix_b_res : fix_a_res[WIDTH-1:0];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        if (ctl_q.is_div) begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {acc_q[DW-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_FINISH;
      end
      MD_FINISH: begin
        fix_a_val = ctl_q.is_div ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;
        fix_a_neg = ctl_q.res_neg;
        fix_b_val = acc_q[DW-1:WIDTH];
        fix_b_neg = ctl_q.rem_neg;
        if (ctl_q.is_div) begin
          // Divide by zero leaves |a| as remainder, so HI reproduces a after fixup.
          lo_d = ctl_q.div0 ? {WIDTH{1'b1}} : fix_a_res[WIDTH-1:0];
          hi_d = fix_b_res;
        end else begin
          hi_d = fix_a_res[DW-1:WIDTH];
          lo_d = fix_a_res[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = MD_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= MD_IDLE;
      ctl_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, busy/write gating, reset.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk_i, reset_i, start_i, hi_we_i, lo_we_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i, wdata_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Launches one op; optionally pokes start+MTHI/MTLO at loop step poke_at.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, output int busy_cnt, output int done_at,
                        output logic [31:0] hi_k1);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    busy_cnt = 0; done_at = 0; hi_k1 = '0;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      @(negedge clk_i);
      if (k == 1) hi_k1 = hi_o;
      if (k == poke_at) begin
        start_i = 1'b1; op_i = MD_DIVU; a_i = 32'd9; b_i = 32'd9;
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
      end else begin
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
      end
      if (done_o) done_at = k;
      else if (busy_o) busy_cnt++;
    end
  endtask

  typedef struct {
    string       tag;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[8];
  int   bc, da, dones;
  logic [31:0] h1;

  initial begin
    vecs[0] = '{"multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_m3x5", MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{"div_m7d2",  MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_by0",  MD_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{"div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{"div_7dm2",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{"div_m5by0", MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{"mult_mix",  MD_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};

    reset_i = 1'b1; start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    reset_i = 1'b0;

    // MTHI then MTLO in IDLE
    hi_we_i = 1'b1; wdata_i = 32'h1234;
    @(negedge clk_i);
    hi_we_i = 1'b0; lo_we_i = 1'b1; wdata_i = 32'hABCD;
    check("mthi", hi_o, 32'h1234);
    check("mthi_busy", busy_o, 0);
    @(negedge clk_i);
    lo_we_i = 1'b0;
    check("mtlo", lo_o, 32'hABCD);
    check("mtlo_hi_kept", hi_o, 32'h1234);
    check("mtlo_busy", busy_o, 0);

    // Directed table, issued back-to-back (start presented during each done cycle)
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, bc, da, h1);
      check({vecs[i].tag, "_lat"}, da, 34);
      check({vecs[i].tag, "_busy"}, bc, 33);
      check({vecs[i].tag, "_hi"}, hi_o, vecs[i].hi);
      check({vecs[i].tag, "_lo"}, lo_o, vecs[i].lo);
    end
    check("done_busy_low", busy_o, 0);
    @(negedge clk_i);
    check("done_one_cycle", done_o, 0);

    // Start and MTHI/MTLO while busy are dropped
    run_op(MD_MULTU, 32'd3, 32'd4, 5, bc, da, h1);
    check("ign_lat", da, 34);
    check("ign_hi", hi_o, 32'h0);
    check("ign_lo", lo_o, 32'd12);
    @(negedge clk_i);
    check("ign_no_relaunch", busy_o, 0);

    // Start together with MTHI in IDLE: write lands, then result overwrites
    hi_we_i = 1'b1; wdata_i = 32'h5555;
    run_op(MD_MULTU, 32'd2, 32'd3, 0, bc, da, h1);
    check("sw_hi_written", h1, 32'h5555);
    check("sw_hi", hi_o, 32'h0);
    check("sw_lo", lo_o, 32'd6);
    @(negedge clk_i);

    // Reset mid-divide
    start_i = 1'b1; op_i = MD_DIV; a_i = 32'hFFFF_FF9C; b_i = 32'd3;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("mrst_busy", busy_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_hi", hi_o, 0);
    check("mrst_lo", lo_o, 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check("mrst_no_done", dones, 0);
    run_op(MD_MULT, 32'd6, 32'd7, 0, bc, da, h1);
    check("post_rst_lat", da, 34);
    check("post_rst_hi", hi_o, 0);
    check("post_rst_lo", lo_o, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
